// File: rtl/dut_delay_line.sv
// dut_delay_line
//    Multi-channel, multi-bit delay line. Its latency is chosen at runtime
//    between 1 and MAX_DEPTH cycles. Each sample carries a valid tag. After
//    reset there is a warm-up window of ITERS cycles, during which input is
//    refused and counted as dropped. The block also has a synchronous flush
//    and a combinational per-channel output enable.
//
// Ports
//    clk        rising-edge clock
//    rst        asynchronous, active-high reset
//    d_in       packed channel data, channel 0 in the LSBs
//    in_valid   d_in qualifier
//    depth_sel  requested latency in cycles (0 -> 1, >MAX_DEPTH -> MAX_DEPTH)
//    flush      synchronous pipeline clear (valid bits and data)
//    chan_en    per-channel output enable; a disabled channel reads as 0
//    ready      high once warm-up is complete and input is accepted
//    d_out      delayed data taken from stage D-1
//    out_valid  d_out qualifier, independent of chan_en
//    drop_cnt   saturating count of refused inputs, cleared only by rst
module dut_delay_line #(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned MAX_DEPTH = 8,
   parameter int unsigned ITERS     = 20,
   parameter int unsigned DW        = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CHANNELS*WIDTH-1:0]        d_in,
   input  logic                             in_valid,
   input  logic [$clog2(MAX_DEPTH+1)-1:0]   depth_sel,
   input  logic                             flush,
   input  logic [CHANNELS-1:0]              chan_en,
   output logic                             ready,
   output logic [CHANNELS*WIDTH-1:0]        d_out,
   output logic                             out_valid,
   output logic [DW-1:0]                    drop_cnt
);

   localparam int unsigned DSW = $clog2(MAX_DEPTH + 1);
   localparam int unsigned CW  = (ITERS > 0) ? $clog2(ITERS + 1) : 1;
   localparam int unsigned BW  = CHANNELS * WIDTH;

   typedef enum logic {WARMUP, RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [BW-1:0]        data_q [MAX_DEPTH];
   logic [MAX_DEPTH-1:0] vld_q;
   logic [DSW-1:0]       depth_q;
   logic [DSW-1:0]       eff_depth;
   logic                 depth_chg;
   logic                 accept;
   logic [DW-1:0]        drop_q;
   logic [BW-1:0]        sel_data;
   logic                 sel_vld;

   // ---------------- warm-up FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if (ITERS == 0) state_q <= RUN;
         else            state_q <= WARMUP;
         cnt_q <= CW'(ITERS);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WARMUP: begin
            cnt_d = cnt_q - CW'(1);
            // The counter reaches 0 on this edge, so ready rises on edge ITERS.
            if (cnt_q == CW'(1)) state_d = RUN;
         end
         RUN: ;
         default: state_d = WARMUP;
      endcase
   end

   assign ready = (state_q == RUN);

   // ---------------- depth selection ----------------
   always_comb begin
      if (depth_sel == '0)
         eff_depth = DSW'(1);
      else if (depth_sel > DSW'(MAX_DEPTH))
         eff_depth = DSW'(MAX_DEPTH);
      else
         eff_depth = depth_sel;
   end

   assign depth_chg = (eff_depth != depth_q);
   assign accept    = in_valid & ready & ~flush;

   // ---------------- delay stages ----------------
   // Data shifts every cycle; only valid bits are cleared on a depth change,
   // while flush clears both. The clear also covers stage 0, so a sample
   // presented on that edge is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MAX_DEPTH; i++) data_q[i] <= '0;
         vld_q   <= '0;
         depth_q <= DSW'(1);
      end else begin
         depth_q <= eff_depth;
         if (flush) begin
            for (int unsigned i = 0; i < MAX_DEPTH; i++) data_q[i] <= '0;
         end else begin
            data_q[0] <= d_in;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) data_q[i] <= data_q[i-1];
         end
         if (flush || depth_chg) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= accept;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // ---------------- drop counter ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else if (in_valid && !ready && !flush && (drop_q != '1)) begin
         drop_q <= drop_q + DW'(1);
      end
   end

   assign drop_cnt = drop_q;

   // ---------------- output mux and channel gating ----------------
   always_comb begin
      sel_data = '0;
      sel_vld  = 1'b0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
         if (depth_q == DSW'(i + 1)) begin
            sel_data = data_q[i];
            sel_vld  = vld_q[i];
         end
      end
   end

   always_comb begin
      d_out = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (chan_en[c]) d_out[c*WIDTH +: WIDTH] = sel_data[c*WIDTH +: WIDTH];
      end
   end

   assign out_valid = sel_vld;

endmodule

// File: tb/tb_dut_delay_line.sv
module tb_dut_delay_line;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] d_in = '0;
   logic        in_valid = 1'b0;
   logic [3:0]  depth_sel = 4'd3;
   logic        flush = 1'b0;
   logic [3:0]  chan_en = 4'b1111;

   logic        ready, out_valid;
   logic [31:0] d_out;
   logic [7:0]  drop_cnt;

   logic        ready4, out_valid4;
   logic [31:0] d_out4;
   logic [3:0]  drop_cnt4;

   logic        ready0, out_valid0;
   logic [31:0] d_out0;
   logic [7:0]  drop_cnt0;

   int checks   = 0;
   int failures = 0;
   logic [7:0] val = 8'h00;

   always #5 clk = ~clk;

   dut_delay_line #(.WIDTH(8), .CHANNELS(4), .MAX_DEPTH(8), .ITERS(20), .DW(8)) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .depth_sel(depth_sel),
      .flush(flush), .chan_en(chan_en), .ready(ready), .d_out(d_out),
      .out_valid(out_valid), .drop_cnt(drop_cnt)
   );

   dut_delay_line #(.WIDTH(8), .CHANNELS(4), .MAX_DEPTH(8), .ITERS(20), .DW(4)) dut4 (
      .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .depth_sel(depth_sel),
      .flush(flush), .chan_en(chan_en), .ready(ready4), .d_out(d_out4),
      .out_valid(out_valid4), .drop_cnt(drop_cnt4)
   );

   dut_delay_line #(.WIDTH(8), .CHANNELS(4), .MAX_DEPTH(8), .ITERS(0), .DW(8)) dut0 (
      .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .depth_sel(depth_sel),
      .flush(flush), .chan_en(chan_en), .ready(ready0), .d_out(d_out0),
      .out_valid(out_valid0), .drop_cnt(drop_cnt0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream_step();
      d_in = {4{val}};
      step();
      val = val + 8'd1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      d_in     = '0;
      for (int i = 0; i < 10; i++) step();
   endtask

   // Warm-up with in_valid held high: ready rises on edge 20, 20 drops counted.
   task automatic warmup_check(input string tag);
      int first;
      first = 0;
      in_valid = 1'b1;
      d_in     = 32'h55AA55AA;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (ready && first == 0) first = k;
      end
      checks++;
      if (first !== 20) begin
         failures++;
         $display("FAIL %s_ready_edge actual=%0d required=20", tag, first);
      end
      checks++;
      if (drop_cnt !== 8'd20) begin
         failures++;
         $display("FAIL %s_drop_cnt actual=%0d required=20", tag, drop_cnt);
      end
      checks++;
      if (drop_cnt4 !== 4'd15) begin
         failures++;
         $display("FAIL %s_drop_sat actual=%0d required=15", tag, drop_cnt4);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_ov_warmup actual=%0b required=0", tag, out_valid);
      end
   endtask

   task automatic test_reset();
      depth_sel = 4'd3;
      #1 rst = 1'b1;
      #2;
      checks++;
      if (ready !== 1'b0 || out_valid !== 1'b0 || d_out !== 32'h0 || drop_cnt !== 8'h0) begin
         failures++;
         $display("FAIL reset_state actual=r%0b v%0b d%h c%0d required=r0 v0 d0 c0",
                  ready, out_valid, d_out, drop_cnt);
      end
      checks++;
      if (ready0 !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_iters0 actual=%0b required=1", ready0);
      end
      step();
      step();
      rst = 1'b0;
      warmup_check("reset");
      // First accepted sample at edge 21, depth 3 -> visible after edge 23.
      d_in = 32'hA1B2C3D4;
      step();
      in_valid = 1'b0;
      d_in     = '0;
      checks++;
      if (drop_cnt !== 8'd20) begin
         failures++;
         $display("FAIL reset_drop_after_ready actual=%0d required=20", drop_cnt);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ov_early actual=%0b required=0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || d_out !== 32'hA1B2C3D4) begin
         failures++;
         $display("FAIL reset_first_out actual=v%0b d%h required=v1 dA1B2C3D4", out_valid, d_out);
      end
   endtask

   task automatic test_depth3();
      drain();
      depth_sel = 4'd3;
      step();
      d_in     = 32'h04030201;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      d_in     = '0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL depth3_n actual=%0b required=0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL depth3_n1 actual=%0b required=0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || d_out !== 32'h04030201) begin
         failures++;
         $display("FAIL depth3_n2 actual=v%0b d%h required=v1 d04030201", out_valid, d_out);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL depth3_n3 actual=%0b required=0", out_valid);
      end
   endtask

   task automatic test_latency(input logic [3:0] sel, input int lat_exp);
      int lat;
      drain();
      depth_sel = sel;
      step();
      step();
      d_in     = 32'hC0DE0000 | 32'(sel);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      d_in     = '0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      checks++;
      if (lat !== lat_exp || d_out !== (32'hC0DE0000 | 32'(sel))) begin
         failures++;
         $display("FAIL latency_sel%0d actual=lat%0d d%h required=lat%0d d%h",
                  sel, lat, d_out, lat_exp, 32'hC0DE0000 | 32'(sel));
      end
   endtask

   task automatic test_depth_change();
      int lows;
      int bad;
      logic [31:0] exp;
      drain();
      depth_sel = 4'd3;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) stream_step();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL chg_steady actual=%0b required=1", out_valid);
      end
      depth_sel = 4'd5;
      exp  = {4{val + 8'd1}};
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         stream_step();
         if (out_valid) break;
         lows++;
      end
      checks++;
      if (lows !== 5 || d_out !== exp) begin
         failures++;
         $display("FAIL chg_gap actual=lows%0d d%h required=lows5 d%h", lows, d_out, exp);
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         exp = {4{val - 8'd4}};
         stream_step();
         if (out_valid !== 1'b1 || d_out !== exp) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL chg_continuous actual=bad%0d required=bad0", bad);
      end
   endtask

   task automatic test_flush();
      int lows;
      logic [7:0]  drop0;
      logic [31:0] exp;
      drain();
      depth_sel = 4'd3;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) stream_step();
      drop0 = drop_cnt;
      flush = 1'b1;
      stream_step();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || d_out !== 32'h0) begin
         failures++;
         $display("FAIL flush_edge actual=v%0b d%h required=v0 d0", out_valid, d_out);
      end
      exp  = {4{val}};
      lows = 1;
      for (int i = 0; i < 20; i++) begin
         stream_step();
         if (out_valid) break;
         lows++;
      end
      checks++;
      if (lows !== 3 || d_out !== exp) begin
         failures++;
         $display("FAIL flush_first actual=lows%0d d%h required=lows3 d%h", lows, d_out, exp);
      end
      checks++;
      if (drop_cnt !== drop0) begin
         failures++;
         $display("FAIL flush_drop actual=%0d required=%0d", drop_cnt, drop0);
      end
   endtask

   task automatic test_chan_en();
      drain();
      depth_sel = 4'd3;
      in_valid  = 1'b1;
      d_in      = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) step();
      chan_en = 4'b0101;
      #1;
      checks++;
      if (d_out !== 32'h00FF00FF || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL chan_en_0101 actual=v%0b d%h required=v1 d00FF00FF", out_valid, d_out);
      end
      chan_en = 4'b1111;
      #1;
      checks++;
      if (d_out !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL chan_en_1111 actual=%h required=FFFFFFFF", d_out);
      end
      chan_en = 4'b0000;
      #1;
      checks++;
      if (d_out !== 32'h0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL chan_en_0000 actual=v%0b d%h required=v1 d0", out_valid, d_out);
      end
      chan_en = 4'b1111;
   endtask

   task automatic test_reset_mid();
      depth_sel = 4'd3;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) stream_step();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (d_out !== 32'h0 || out_valid !== 1'b0 || ready !== 1'b0 || drop_cnt !== 8'h0) begin
         failures++;
         $display("FAIL reset_mid actual=v%0b d%h r%0b c%0d required=v0 d0 r0 c0",
                  out_valid, d_out, ready, drop_cnt);
      end
      step();
      rst = 1'b0;
      warmup_check("rst_mid");
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_depth3();
      test_latency(4'd0, 1);
      test_latency(4'd15, 8);
      test_latency(4'd5, 5);
      test_latency(4'd8, 8);
      test_depth_change();
      test_flush();
      test_chan_en();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dut_delay_line.md
Name: dut_delay_line

Overview:
- Parametrised successor to the single-bit, two-register delay block.
- Multi-channel, multi-bit delay line with a runtime-selectable depth, valid tagging, a post-reset warm-up window of ITERS cycles, synchronous flush and per-channel output enables.
- Sits between the sampling front end and downstream consumers to align channel data to a programmable latency.

Parameters:
- WIDTH, 1, data bits per channel.
- CHANNELS, 4, number of parallel channels.
- MAX_DEPTH, 8, number of physical delay stages (>=1).
- ITERS, 20, warm-up cycles after reset release during which input is refused (>=0).
- DW, 8, width of drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  CHANNELS*WIDTH  packed channel data, channel 0 in LSBs.
- in_valid  input  1  d_in qualifier.
- depth_sel  input  $clog2(MAX_DEPTH+1)  requested latency in cycles.
- flush  input  1  synchronous pipeline clear.
- chan_en  input  CHANNELS  per-channel output enable.
- ready  output  1  high when input is accepted (warm-up complete).
- d_out  output  CHANNELS*WIDTH  delayed data, disabled channels forced to 0.
- out_valid  output  1  d_out qualifier.
- drop_cnt  output  DW  saturating count of refused inputs.

Behaviour:
- Reset (async, immediate): all stage data = 0, all stage valid bits = 0, d_out = 0, out_valid = 0, drop_cnt = 0, warm-up counter = ITERS.
- ready on reset = 0, or 1 if ITERS = 0.
- States:
  - WARMUP: entered on reset when ITERS > 0. Counter decrements once per rising edge. Move to RUN on the edge where the counter reaches 0. ready is registered and rises on the ITERS-th rising edge after rst deasserts.
  - RUN: ready = 1. Stays in RUN until the next rst.
- Pipeline advances every cycle; there is no stall.
- Stage 0 captures d_in every edge.
- Stage 0 valid = in_valid & ready & !flush.
- Stage k captures stage k-1 data and valid.
- Effective depth D:
  - D = 1 when depth_sel = 0.
  - D = MAX_DEPTH when depth_sel > MAX_DEPTH.
  - Otherwise D = depth_sel.
- Output path:
  - d_out and out_valid are driven from stage D-1, combinationally muxed from registers.
  - A sample accepted at edge n appears on the outputs after edge n+D-1, i.e. visible during cycle n+D-1 (latency D edges from presentation).
- Channel c of d_out = 0 when chan_en[c] = 0. Gating is combinational and does not alter stored data.
- out_valid is independent of chan_en.
- Depth change: when the registered depth differs from the new effective depth, all valid bits clear on that edge (data kept) and the new D takes effect. out_valid stays 0 until fresh samples traverse D stages.
- Flush: all valid bits clear on the edge where flush = 1, and stage data is zeroed. A coincident in_valid is discarded and not counted as dropped. Flush during WARMUP does not affect the warm-up counter.
- Drop counting: drop_cnt increments when in_valid = 1 & ready = 0 & flush = 0. It saturates at 2^DW-1 and clears only on rst.
- Reset mid-operation: all state clears immediately, including in-flight samples. The warm-up window restarts from ITERS.
- Simultaneous depth change and flush: both apply; result is all valid = 0 and data = 0.

Test Plan:
- Reset, ITERS=20: hold in_valid=1 from rst release → ready rises on edge 20; drop_cnt = 20; out_valid = 0 until first accepted sample emerges.
- RUN, depth_sel=3, CHANNELS=4, WIDTH=8, inject d_in=0x04030201 at edge n → d_out=0x04030201 and out_valid=1 during cycle n+2 only.
- depth_sel=0 → latency 1. depth_sel=15 with MAX_DEPTH=8 → latency 8. Change depth 3→5 mid-stream → out_valid low for exactly 5 cycles, then continuous.
- Stream incrementing data with flush pulsed one cycle at edge m → no sample presented at or before m emerges; first valid output is the sample accepted at m+1; drop_cnt unchanged.
- chan_en=4'b0101 with d_in=0xFFFFFFFF → d_out=0x00FF00FF, out_valid=1; toggle chan_en to 4'b1111 → full word reappears the same cycle.
- DW=4, hold in_valid during 20-cycle warm-up → drop_cnt saturates at 15. Assert rst asynchronously mid-stream → outputs zero immediately; ready low again for ITERS cycles.
